phase_to_iq: RTL and testbench



---
 rtl/phase_to_iq.sv | 127 ++++++++++++
 tb/tb_phase_to_iq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/phase_to_iq.sv
// Four-lane phase-to-amplitude converter: quarter-wave sine ROM with quadrant
// folding, three registered stages, producing I/Q local-oscillator samples.
module phase_to_iq #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned LANES   = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned AMP_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  input  logic [LANES*PHASE_W-1:0] phase_i,
  output logic                     valid_o,
  output logic [LANES*AMP_W-1:0]   sin_o,
  output logic [LANES*AMP_W-1:0]   cos_o
);

  localparam int unsigned ROM_D = 2**ADDR_W;
  localparam int unsigned MAG_W = AMP_W - 1;

  // T[a] = round((2^MAG_W-1) * sin(pi/2 * (a+0.5)/ROM_D)), evaluated in 2^-60
  // fixed point by Taylor series so the table is fixed at elaboration.
  function automatic logic [MAG_W-1:0] quarter_sine(input int unsigned a);
    logic [127:0] half_pi;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    logic [127:0] scaled;
    half_pi = 128'h1921FB54442D1846;
    x       = (half_pi * 128'(2 * a + 1)) >> (ADDR_W + 1);
    x2      = (x * x) >> 60;
    term    = x;
    sum     = x;
    for (int unsigned n = 1; n <= 12; n++) begin
      term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
      if (n[0]) sum = sum - term;
      else      sum = sum + term;
    end
    scaled = sum * 128'((2**MAG_W) - 1) + (128'(1) << 59);
    return MAG_W'(scaled >> 60);
  endfunction

  logic [MAG_W-1:0] rom [ROM_D];

  for (genvar g = 0; g < ROM_D; g++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = quarter_sine(g);
    assign rom[g] = ENTRY;
  end

  // Only the top ADDR_W+2 bits of each phase word select the sample.
  logic [LANES*PHASE_W-1:0] unused_phase;
  assign unused_phase = phase_i;

  logic [ADDR_W+1:0]              idx;
  logic [LANES-1:0][ADDR_W-1:0]   sin_addr_d, cos_addr_d;
  logic [LANES-1:0]               sin_neg_d, cos_neg_d;

  always_comb begin
    idx        = '0;
    sin_addr_d = '0;
    cos_addr_d = '0;
    sin_neg_d  = '0;
    cos_neg_d  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx = phase_i[k*PHASE_W + PHASE_W - 1 -: ADDR_W + 2];
      // Odd quadrants read the mirrored address; cosine is sine one quadrant on.
      sin_addr_d[k] = idx[ADDR_W] ? ~idx[ADDR_W-1:0] : idx[ADDR_W-1:0];
      cos_addr_d[k] = idx[ADDR_W] ? idx[ADDR_W-1:0] : ~idx[ADDR_W-1:0];
      sin_neg_d[k]  = idx[ADDR_W+1];
      cos_neg_d[k]  = idx[ADDR_W+1] ^ idx[ADDR_W];
    end
  end

  logic                          v1, v2;
  logic [LANES-1:0][ADDR_W-1:0]  s1_sin_addr, s1_cos_addr;
  logic [LANES-1:0]              s1_sin_neg, s1_cos_neg;
  logic [LANES-1:0][MAG_W-1:0]   s2_sin_mag, s2_cos_mag;
  logic [LANES-1:0]              s2_sin_neg, s2_cos_neg;
  logic [LANES-1:0][AMP_W-1:0]   s3_sin, s3_cos;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      valid_o     <= 1'b0;
      s1_sin_addr <= '0;
      s1_cos_addr <= '0;
      s1_sin_neg  <= '0;
      s1_cos_neg  <= '0;
      s2_sin_mag  <= '0;
      s2_cos_mag  <= '0;
      s2_sin_neg  <= '0;
      s2_cos_neg  <= '0;
      s3_sin      <= '0;
      s3_cos      <= '0;
    end else begin
      v1      <= valid_i;
      v2      <= v1;
      valid_o <= v2;
      if (valid_i) begin
        s1_sin_addr <= sin_addr_d;
        s1_cos_addr <= cos_addr_d;
        s1_sin_neg  <= sin_neg_d;
        s1_cos_neg  <= cos_neg_d;
      end
      if (v1) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          s2_sin_mag[k] <= rom[s1_sin_addr[k]];
          s2_cos_mag[k] <= rom[s1_cos_addr[k]];
        end
        s2_sin_neg <= s1_sin_neg;
        s2_cos_neg <= s1_cos_neg;
      end
      if (v2) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          s3_sin[k] <= s2_sin_neg[k] ? -{1'b0, s2_sin_mag[k]} : {1'b0, s2_sin_mag[k]};
          s3_cos[k] <= s2_cos_neg[k] ? -{1'b0, s2_cos_mag[k]} : {1'b0, s2_cos_mag[k]};
        end
      end
    end
  end

  assign sin_o = s3_sin;
  assign cos_o = s3_cos;

endmodule

// File: tb/tb_phase_to_iq.sv
// Bench for phase_to_iq: directed vectors plus a floating-point sine/cosine
// reference with a 3-cycle delay line, compared every cycle.
module tb_phase_to_iq;

  localparam real PI = 3.14159265358979323846;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b1;
  logic         valid_i = 1'b0;
  logic [127:0] phase_i = '0;
  logic         valid_o;
  logic [63:0]  sin_o;
  logic [63:0]  cos_o;

  int errors   = 0;
  int checks   = 0;
  int vo_count = 0;
  bit check_en = 1'b0;

  phase_to_iq #(
    .PHASE_W(32),
    .LANES  (4),
    .ADDR_W (10),
    .AMP_W  (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(valid_i),
    .phase_i(phase_i),
    .valid_o(valid_o),
    .sin_o  (sin_o),
    .cos_o  (cos_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Sample value is the rounded sine of the bin centre of the top 12 phase bits.
  function automatic logic [15:0] ref_amp(input logic [31:0] ph, input bit is_cos);
    real ang;
    real v;
    real r;
    int  p;
    p   = int'(ph[31:20]);
    ang = 2.0 * PI * (real'(p) + 0.5) / 4096.0;
    v   = 32767.0 * (is_cos ? $cos(ang) : $sin(ang));
    r   = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
    return 16'($rtoi(r));
  endfunction

  function automatic logic [63:0] model_word(input logic [127:0] ph, input bit is_cos);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w[16*k +: 16] = ref_amp(ph[32*k +: 32], is_cos);
    return w;
  endfunction

  function automatic logic [63:0] lit4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: inputs delayed by the pipeline depth, output held between valid words.
  logic [2:0]   m_valid;
  logic [127:0] m_ph0, m_ph1;
  logic [63:0]  m_sin, m_cos;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= '0;
      m_sin   <= '0;
      m_cos   <= '0;
    end else begin
      m_valid <= {m_valid[1:0], valid_i};
      m_ph0   <= phase_i;
      m_ph1   <= m_ph0;
      if (m_valid[1]) begin
        m_sin <= model_word(m_ph1, 1'b0);
        m_cos <= model_word(m_ph1, 1'b1);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("valid_o", 64'(valid_o), 64'(m_valid[2]));
      check("sin_o", sin_o, m_sin);
      check("cos_o", cos_o, m_cos);
      if (valid_o) vo_count++;
    end
  end

  task automatic drive(input logic v, input logic [127:0] ph);
    @(negedge clk);
    valid_i = v;
    phase_i = ph;
  endtask

  initial begin
    logic [31:0] acc;
    logic [31:0] inc;
    logic [31:0] x;
    bit          pat [6];

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset valid_o", 64'(valid_o), 64'd0);
    check("reset sin_o", sin_o, 64'd0);
    check("reset cos_o", cos_o, 64'd0);

    check("model sin p0", 64'(ref_amp(32'h0000_0000, 1'b0)), 64'(16'd25));
    check("model sin p1", 64'(ref_amp(32'h0010_0000, 1'b0)), 64'(16'd75));
    check("model sin p4095", 64'(ref_amp(32'hFFFF_FFFF, 1'b0)), 64'(16'hFFE7));
    check("model cos p1024", 64'(ref_amp(32'h4000_0000, 1'b1)), 64'(16'hFFE7));

    check_en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Cardinal phases, single valid word.
    drive(1'b1, {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    drive(1'b0, rnd128());
    drive(1'b0, rnd128());
    @(negedge clk);
    check("cardinal valid", 64'(valid_o), 64'd1);
    check("cardinal sin", sin_o, lit4(25, 32767, -25, -32767));
    check("cardinal cos", cos_o, lit4(32767, -25, -32767, 25));
    @(negedge clk);
    check("cardinal valid drop", 64'(valid_o), 64'd0);
    check("cardinal sin hold", sin_o, lit4(25, 32767, -25, -32767));

    // Wrap-around and truncation of the low phase bits.
    drive(1'b1, {32'h4000_0000, 32'h0010_0000, 32'h000F_FFFF, 32'hFFFF_FFFF});
    drive(1'b0, rnd128());
    drive(1'b0, rnd128());
    @(negedge clk);
    check("wrap sin", sin_o, lit4(-25, 25, 75, 32767));
    check("wrap cos", cos_o, lit4(32767, 32767, 32767, -25));

    // Valid gaps reappear three cycles later.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive((i < 6) ? logic'(pat[i]) : 1'b0, rnd128());
      if (i >= 3 && i < 9) check("gap valid pattern", 64'(valid_o), 64'(pat[i-3]));
      else if (i >= 9) check("gap valid idle", 64'(valid_o), 64'd0);
    end

    // Accumulator stream, 100 back-to-back words.
    vo_count = 0;
    acc = '0;
    inc = 32'h0100_0000;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, {acc + 3*inc, acc + 2*inc, acc + inc, acc});
      acc = acc + 4*inc;
    end
    repeat (6) drive(1'b0, rnd128());
    check("stream valid count", 64'(vo_count), 64'd100);

    // Half- and quarter-turn offsets across lanes.
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      drive(1'b1, {$urandom, x + 32'h4000_0000, x + 32'h8000_0000, x});
    end
    repeat (4) drive(1'b0, rnd128());

    // Reset asserted mid-stream between edges.
    repeat (5) drive(1'b1, rnd128());
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset valid_o", 64'(valid_o), 64'd0);
    check("midreset sin_o", sin_o, 64'd0);
    check("midreset cos_o", cos_o, 64'd0);
    repeat (3) drive(1'b1, rnd128());
    #2 rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, rnd128());
      check("post-reset valid", 64'(valid_o), (j >= 2) ? 64'd1 : 64'd0);
    end
    repeat (5) drive(1'b0, rnd128());

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
